seq_packer: RTL

Multi-cycle fixed-point to IEEE-754 single-precision converter. It is the return path of the CORDIC datapath: it takes a signed fixed-point result and produces a 32-bit float for the Nios II custom-instruction result bus. It uses a start/done handshake and normalizes iteratively, one bit shift per cycle, in place of a wide combinational leading-zero shifter. This keeps Fmax high on the custom-instruction path.

---
 rtl/seq_packer_pkg.sv | 8 +
 rtl/seq_packer_if.sv | 11 +
 rtl/seq_packer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/seq_packer_pkg.sv
// Shared types and float-format constants for the fixed-point to IEEE-754 packer.
package seq_packer_pkg;
  typedef enum logic [1:0] {IDLE, ABS, NORM, PACK} state_e;

  localparam int FLOAT_BIAS = 127;
  localparam int MANT_BITS  = 23;
  localparam int EXP_BITS   = 8;
endpackage

// File: rtl/seq_packer_if.sv
// Start/done handshake bundle between the CORDIC return path and the packer.
interface seq_packer_if #(parameter int WIDTH = 22) ();
  logic             start;
  logic [WIDTH+1:0] data_in;
  logic             busy;
  logic             done;
  logic [31:0]      result;

  modport master (output start, data_in, input busy, done, result);
  modport slave  (input start, data_in, output busy, done, result);
endinterface

// File: rtl/seq_packer.sv
// Iterative signed fixed-point (1 int + WIDTH frac bits) to IEEE-754 single converter.
// Latency k+3 edges (zero: 2); define SEQ_PACKER_RNE_EN for round-to-nearest-even instead of truncation.
module seq_packer
  import seq_packer_pkg::*;
#(
  parameter int WIDTH = 22
) (
  input  logic         clk,
  input  logic         reset,
  seq_packer_if.slave  bus
);

  localparam int MW   = WIDTH + 2;
  localparam int KW   = $clog2(WIDTH + 2) + 1;
  localparam int EXTW = WIDTH + 1 + MANT_BITS;

  state_e               state_q, state_d;
  logic [MW-1:0]        mag_q, mag_d;
  logic [KW-1:0]        k_q, k_d;
  logic                 sign_q, sign_d;
  logic                 zero_q, zero_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [31:0]          result_q, result_d;

  logic [EXTW-1:0]      ext;
  logic [MANT_BITS-1:0] mant;
  logic [EXP_BITS-1:0]  expo;
  logic [31:0]          packed_val;

  // Bits below the normalized MSB, right-padded so narrow WIDTHs still fill the mantissa.
  always_comb begin
    ext  = {mag_q[WIDTH:0], {MANT_BITS{1'b0}}};
    mant = MANT_BITS'(ext >> (EXTW - MANT_BITS));
    expo = EXP_BITS'(FLOAT_BIAS + 1) - EXP_BITS'(k_q);
`ifdef SEQ_PACKER_RNE_EN
    begin
      logic                 guard;
      logic                 sticky;
      logic [MANT_BITS:0]   mant_r;
      guard  = ext[WIDTH];
      sticky = |ext[WIDTH-1:0];
      mant_r = {1'b0, mant} + (MANT_BITS+1)'(guard & (sticky | mant[0]));
      mant   = mant_r[MANT_BITS-1:0];
      if (mant_r[MANT_BITS]) begin
        expo = expo + EXP_BITS'(1);
      end
    end
`endif
    packed_val = {sign_q, expo, mant};
  end

  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    k_d      = k_q;
    sign_d   = sign_q;
    zero_d   = zero_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mag_d   = bus.data_in;
          sign_d  = bus.data_in[MW-1];
          busy_d  = 1'b1;
          state_d = ABS;
        end
      end
      ABS: begin
        k_d = '0;
        if (mag_q == '0) begin
          zero_d  = 1'b1;
          state_d = PACK;
        end else begin
          zero_d  = 1'b0;
          // Negating the most negative code wraps to itself, which reads correctly as unsigned 2.0.
          mag_d   = sign_q ? (~mag_q + MW'(1)) : mag_q;
          state_d = NORM;
        end
      end
      NORM: begin
        if (mag_q[MW-1]) begin
          state_d = PACK;
        end else begin
          mag_d = mag_q << 1;
          k_d   = k_q + KW'(1);
        end
      end
      PACK: begin
        result_d = zero_q ? 32'h0 : packed_val;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mag_q    <= '0;
      k_q      <= '0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      k_q      <= k_d;
      sign_q   <= sign_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule
